// File: rtl/mm_quantum_arbitrator_pkg.sv
// Shared types and helpers for the quantum-limited round-robin arbiter.
// The package holds the FSM state encoding and the index wrap helper.
package mm_pkg;

    typedef enum logic [0:0] {
        MM_IDLE  = 1'b0,
        MM_GRANT = 1'b1
    } mm_state_e;

    // Successor of idx in a ring of n entries.
    function automatic int unsigned mm_wrap_next(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 32'd1;
        if (nxt >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mm_quantum_arbitrator_if.sv
// Bus bundle between the masters, the arbiter and the single downstream slave.
// The arbiter connects through the arb modport.
interface mm_quantum_arbitrator_if #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int MASTERS = 3
);
    logic [MASTERS-1:0][AWIDTH-1:0] s_addr;
    logic [MASTERS-1:0]             s_wreq;
    logic [MASTERS-1:0][DWIDTH-1:0] s_wdat;
    logic [MASTERS-1:0]             s_rreq;
    logic [MASTERS-1:0][DWIDTH-1:0] s_rdat;
    logic [MASTERS-1:0]             s_busy;

    logic [AWIDTH-1:0]              m_addr;
    logic                           m_wreq;
    logic [DWIDTH-1:0]              m_wdat;
    logic                           m_rreq;
    logic [DWIDTH-1:0]              m_rdat;
    logic                           m_busy;

    modport arb (
        input  s_addr, s_wreq, s_wdat, s_rreq, m_rdat, m_busy,
        output s_rdat, s_busy, m_addr, m_wreq, m_wdat, m_rreq
    );

    modport master (
        output s_addr, s_wreq, s_wdat, s_rreq,
        input  s_rdat, s_busy
    );

    modport slave (
        input  m_addr, m_wreq, m_wdat, m_rreq,
        output m_rdat, m_busy
    );

endinterface

// File: rtl/mm_quantum_arbitrator_rr_select.sv
// Combinational round-robin picker: first set bit of i_req at or after i_start,
// wrapping, reported as one-hot, index and found flag.
module mm_rr_select #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_sel,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [IW-1:0] w_pos;
    logic          w_hit;

    // Walk the ring from i_start; only the first hit sets a select bit.
    always_comb begin
        o_sel   = {N{1'b0}};
        o_idx   = {IW{1'b0}};
        o_found = 1'b0;
        w_pos   = {IW{1'b0}};
        w_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos        = IW'((int'(i_start) + k) % N);
            w_hit        = i_req[w_pos] & ~o_found;
            o_sel[w_pos] = w_hit;
            o_idx        = w_hit ? w_pos : o_idx;
            o_found      = o_found | w_hit;
        end
    end

endmodule

// File: rtl/mm_quantum_arbitrator.sv
// Round-robin arbiter granting one master the slave port for at most QUANTUM
// accepted transactions per tenure, with zero-bubble hand-over.
module mm_quantum_arbitrator
    import mm_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int MASTERS = 3,
    parameter int QUANTUM = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    mm_quantum_arbitrator_if.arb       bus,
    output logic [$clog2(MASTERS)-1:0] owner,
    output logic                       owner_vld
);

    localparam int IW = $clog2(MASTERS);
    localparam int CW = $clog2(QUANTUM + 1);

    mm_state_e          r_state, w_nxt_state;
    logic [MASTERS-1:0] r_grant, w_nxt_grant;
    logic [IW-1:0]      r_owner, w_nxt_owner;
    logic               r_owner_vld, w_nxt_owner_vld;
    logic [CW-1:0]      r_cnt, w_nxt_cnt;
    logic [IW-1:0]      r_ptr, w_nxt_ptr;

    logic [MASTERS-1:0] w_req;
    logic [MASTERS-1:0] w_grant;
    logic [AWIDTH-1:0]  w_m_addr;
    logic [DWIDTH-1:0]  w_m_wdat;
    logic               w_m_wreq;
    logic               w_m_rreq;
    logic               w_acc;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_owner_req;
    logic               w_release;
    logic [IW-1:0]      w_next_start;

    logic [MASTERS-1:0] w_idle_sel, w_rel_sel;
    logic [IW-1:0]      w_idle_idx, w_rel_idx;
    logic               w_idle_found, w_rel_found;

    assign w_req = bus.s_wreq | bus.s_rreq;

    // Gate the grant with reset so the slave port is quiet from the first reset cycle.
    assign w_grant = reset ? r_grant : {MASTERS{1'b0}};

    // AND-OR multiplex of the granted master onto the slave port.
    always_comb begin
        w_m_addr = {AWIDTH{1'b0}};
        w_m_wdat = {DWIDTH{1'b0}};
        w_m_wreq = 1'b0;
        w_m_rreq = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            w_m_addr = w_m_addr | ({AWIDTH{w_grant[i]}} & bus.s_addr[i]);
            w_m_wdat = w_m_wdat | ({DWIDTH{w_grant[i]}} & bus.s_wdat[i]);
            w_m_wreq = w_m_wreq | (w_grant[i] & bus.s_wreq[i]);
            w_m_rreq = w_m_rreq | (w_grant[i] & bus.s_rreq[i]);
        end
    end

    assign bus.m_addr = w_m_addr;
    assign bus.m_wdat = w_m_wdat;
    assign bus.m_wreq = w_m_wreq;
    assign bus.m_rreq = w_m_rreq;
    assign bus.s_busy = ~w_grant | {MASTERS{bus.m_busy}};
    assign bus.s_rdat = {MASTERS{bus.m_rdat}};

    assign owner     = r_owner;
    assign owner_vld = r_owner_vld;

    // A simultaneous write+read counts as a single acceptance.
    assign w_acc        = (w_m_wreq | w_m_rreq) & ~bus.m_busy;
    assign w_cnt_inc    = r_cnt + CW'(w_acc);
    assign w_owner_req  = w_req[r_owner];
    assign w_release    = (r_state == MM_GRANT)
                        & (~w_owner_req | (w_acc & (w_cnt_inc == CW'(QUANTUM))));
    assign w_next_start = IW'(mm_wrap_next(32'(r_owner), 32'(MASTERS)));

    mm_rr_select #(.N(MASTERS), .IW(IW)) u_idle_select (
        .i_req   (w_req),
        .i_start (r_ptr),
        .o_sel   (w_idle_sel),
        .o_idx   (w_idle_idx),
        .o_found (w_idle_found)
    );

    // Starting one past the owner leaves the owner itself as the last candidate.
    mm_rr_select #(.N(MASTERS), .IW(IW)) u_rel_select (
        .i_req   (w_req),
        .i_start (w_next_start),
        .o_sel   (w_rel_sel),
        .o_idx   (w_rel_idx),
        .o_found (w_rel_found)
    );

    // Next-state and next-grant decision.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_grant     = r_grant;
        w_nxt_owner     = r_owner;
        w_nxt_owner_vld = r_owner_vld;
        w_nxt_cnt       = r_cnt;
        w_nxt_ptr       = r_ptr;
        case (r_state)
            MM_IDLE: begin
                w_nxt_cnt = {CW{1'b0}};
                if (w_idle_found) begin
                    w_nxt_state     = MM_GRANT;
                    w_nxt_grant     = w_idle_sel;
                    w_nxt_owner     = w_idle_idx;
                    w_nxt_owner_vld = 1'b1;
                end else begin
                    w_nxt_grant     = {MASTERS{1'b0}};
                    w_nxt_owner     = {IW{1'b0}};
                    w_nxt_owner_vld = 1'b0;
                end
            end
            MM_GRANT: begin
                if (w_release) begin
                    w_nxt_ptr = w_next_start;
                    w_nxt_cnt = {CW{1'b0}};
                    if (w_rel_found) begin
                        w_nxt_grant     = w_rel_sel;
                        w_nxt_owner     = w_rel_idx;
                        w_nxt_owner_vld = 1'b1;
                    end else begin
                        w_nxt_state     = MM_IDLE;
                        w_nxt_grant     = {MASTERS{1'b0}};
                        w_nxt_owner     = {IW{1'b0}};
                        w_nxt_owner_vld = 1'b0;
                    end
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end
            default: begin
                w_nxt_state     = MM_IDLE;
                w_nxt_grant     = {MASTERS{1'b0}};
                w_nxt_owner     = {IW{1'b0}};
                w_nxt_owner_vld = 1'b0;
                w_nxt_cnt       = {CW{1'b0}};
                w_nxt_ptr       = {IW{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= MM_IDLE;
            r_grant     <= {MASTERS{1'b0}};
            r_owner     <= {IW{1'b0}};
            r_owner_vld <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_ptr       <= {IW{1'b0}};
        end else begin
            r_state     <= w_nxt_state;
            r_grant     <= w_nxt_grant;
            r_owner     <= w_nxt_owner;
            r_owner_vld <= w_nxt_owner_vld;
            r_cnt       <= w_nxt_cnt;
            r_ptr       <= w_nxt_ptr;
        end
    end

endmodule

// File: tb/tb_mm_quantum_arbitrator.sv
// Scoreboard bench: a tenure-level reference model predicts every cycle's
// port values; a negedge monitor compares them against the arbiter.
module tb_mm_quantum_arbitrator;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int M  = 3;
    localparam int Q  = 2;
    localparam int IW = $clog2(M);

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] owner;
    logic          owner_vld;

    mm_quantum_arbitrator_if #(.AWIDTH(AW), .DWIDTH(DW), .MASTERS(M)) bus ();

    mm_quantum_arbitrator #(.AWIDTH(AW), .DWIDTH(DW), .MASTERS(M), .QUANTUM(Q)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .owner     (owner),
        .owner_vld (owner_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] owner;
        logic          vld;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic          wreq;
        logic          rreq;
        logic [M-1:0]  busy;
        logic [DW-1:0] rdat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: current owner (-1 = nobody), accepted count, search start.
    int md_own = -1;
    int md_cnt = 0;
    int md_ptr = 0;

    function automatic int rr_pick(input logic [M-1:0] req, input int start);
        for (int k = 0; k < M; k++) begin
            if (req[(start + k) % M]) return (start + k) % M;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic [M-1:0] wq, input logic [M-1:0] rq,
                         input logic bsy);
        exp_t          e;
        logic [AW-1:0] addr [M];
        logic [DW-1:0] wdat [M];
        logic [DW-1:0] rdat;
        logic [M-1:0]  req;
        logic          acc;
        @(posedge clk);
        #1;
        rdat = DW'($urandom);
        for (int i = 0; i < M; i++) begin
            addr[i] = AW'($urandom);
            wdat[i] = DW'($urandom);
            bus.s_addr[i] = addr[i];
            bus.s_wdat[i] = wdat[i];
        end
        reset       = rst;
        bus.s_wreq  = wq;
        bus.s_rreq  = rq;
        bus.m_busy  = bsy;
        bus.m_rdat  = rdat;

        e.vld   = (md_own >= 0);
        e.owner = e.vld ? IW'(md_own) : '0;
        e.rdat  = rdat;
        if (rst && md_own >= 0) begin
            e.addr = addr[md_own];
            e.wdat = wdat[md_own];
            e.wreq = wq[md_own];
            e.rreq = rq[md_own];
            e.busy = ~(M'(1) << md_own) | {M{bsy}};
        end else begin
            e.addr = '0;
            e.wdat = '0;
            e.wreq = 1'b0;
            e.rreq = 1'b0;
            e.busy = {M{1'b1}};
        end
        sb_q.push_back(e);

        req = wq | rq;
        if (!rst) begin
            md_own = -1;
            md_cnt = 0;
            md_ptr = 0;
        end else if (md_own < 0) begin
            md_own = rr_pick(req, md_ptr);
            md_cnt = 0;
        end else begin
            acc = req[md_own] && !bsy;
            if (acc) md_cnt++;
            if (!req[md_own] || (acc && md_cnt == Q)) begin
                md_ptr = (md_own + 1) % M;
                md_own = rr_pick(req, md_ptr);
                md_cnt = 0;
            end
        end
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("owner_vld", 32'(owner_vld),   32'(e.vld));
                check("owner",     32'(owner),       32'(e.owner));
                check("m_wreq",    32'(bus.m_wreq),  32'(e.wreq));
                check("m_rreq",    32'(bus.m_rreq),  32'(e.rreq));
                check("m_addr",    32'(bus.m_addr),  32'(e.addr));
                check("m_wdat",    32'(bus.m_wdat),  32'(e.wdat));
                check("s_busy",    32'(bus.s_busy),  32'(e.busy));
                for (int i = 0; i < M; i++) begin
                    check("s_rdat", 32'(bus.s_rdat[i]), 32'(e.rdat));
                end
            end
        end
    end

    initial begin
        reset      = 1'b0;
        bus.s_wreq = '0;
        bus.s_rreq = '0;
        bus.s_addr = '0;
        bus.s_wdat = '0;
        bus.m_busy = 1'b0;
        bus.m_rdat = '0;

        repeat (3) cycle(1'b0, 3'b000, 3'b000, 1'b0);
        // M0 and M2 both requesting: alternating two-transaction tenures.
        repeat (8) cycle(1'b1, 3'b001, 3'b100, 1'b0);
        cycle(1'b1, 3'b000, 3'b000, 1'b0);
        // M1 alone: continuous acceptance across quantum boundaries.
        repeat (7) cycle(1'b1, 3'b010, 3'b000, 1'b0);
        cycle(1'b1, 3'b000, 3'b000, 1'b0);
        // M0 held by m_busy mid-tenure.
        repeat (2) cycle(1'b1, 3'b001, 3'b000, 1'b0);
        repeat (3) cycle(1'b1, 3'b001, 3'b000, 1'b1);
        repeat (2) cycle(1'b1, 3'b001, 3'b000, 1'b0);
        cycle(1'b1, 3'b000, 3'b000, 1'b0);
        // M2 owner drops while M0 and M1 request.
        repeat (2) cycle(1'b1, 3'b100, 3'b000, 1'b0);
        repeat (3) cycle(1'b1, 3'b011, 3'b000, 1'b0);
        cycle(1'b1, 3'b000, 3'b000, 1'b0);
        // M0 write and read together.
        repeat (3) cycle(1'b1, 3'b001, 3'b001, 1'b0);
        cycle(1'b1, 3'b000, 3'b000, 1'b0);
        // Reset mid-tenure of M1, then M1 and M2 contend.
        repeat (2) cycle(1'b1, 3'b010, 3'b000, 1'b0);
        cycle(1'b0, 3'b010, 3'b000, 1'b0);
        repeat (4) cycle(1'b1, 3'b110, 3'b000, 1'b0);
        // Random traffic with occasional reset and busy.
        repeat (3000) begin
            cycle(($urandom_range(0, 63) != 0), M'($urandom), M'($urandom) & M'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
